fifo_arb_ctrl: RTL

Controller for a shared circular-buffer FIFO (default 4 x 8-bit entries) that two producers write into and one consumer drains. It arbitrates the two write requesters round-robin and owns the read/write pointers. It drives the storage array's write-enable, addresses and data, and reports occupancy and error flags. It sits between producer logic and an external register-file storage array, so the storage stays a dumb memory.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_arb_ctrl_if.sv | 48 ++++
 rtl/rr_arb2.sv | 46 ++++
 rtl/fifo_arb_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults, types and helpers for the two-producer
//                FIFO controller and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Which producer wins when both request in the same cycle
    typedef enum logic {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } prio_t;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_ctrl_if
//  Description : Producer, consumer and storage-array signals of the
//                two-producer FIFO controller. The controller takes the
//                slave view; producer/consumer/storage logic takes master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_arb_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = occ_w(DEPTH);

    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              gnt0;
    logic              gnt1;
    logic              pop;
    logic              rd_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              err_udf;

    modport master (
        output req0, data0, req1, data1, pop,
        input  gnt0, gnt1, rd_valid, mem_we, mem_waddr, mem_wdata,
               mem_raddr, count, full, empty, err_udf
    );

    modport slave (
        input  req0, data0, req1, data1, pop,
        output gnt0, gnt1, rd_valid, mem_we, mem_waddr, mem_wdata,
               mem_raddr, count, full, empty, err_udf
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Grants are combinational and
//                one-hot or zero; the priority flips to the other requester
//                after every grant and holds otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fifo_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    input  wire logic       enable,
    output logic      [1:0] gnt
);

    prio_t r_prio;

    // Grant selection; suppressed while in reset or when the FIFO is full
    always_comb begin
        gnt = 2'b00;
        if (enable && !rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_prio == PRIO_P1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Priority hand-off: whoever was just served goes to the back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PRIO_P0;
        end else if (gnt[0]) begin
            r_prio <= PRIO_P1;
        end else if (gnt[1]) begin
            r_prio <= PRIO_P0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_ctrl
//  Description : Controller for a shared circular-buffer FIFO with two
//                round-robin arbitrated producers and one consumer. Drives
//                an external storage array and reports occupancy and a
//                sticky underflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)(
    input  wire logic       clk,
    input  wire logic       rst,
    fifo_arb_ctrl_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = occ_w(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    // Pointers carry a wrap bit so they count modulo 2*DEPTH
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_valid;
    logic              r_err_udf;

    logic [1:0]        w_gnt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W:0]   w_ptr_occ;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.req1, bus.req0}),
        .enable (~w_full),
        .gnt    (w_gnt)
    );

    // A full FIFO never grants, so a push is always safe to accept;
    // a pop is only honoured when something is stored.
    assign w_push  = |w_gnt;
    assign w_pop   = bus.pop & ~w_empty;
    assign w_wdata = w_gnt[1] ? bus.data1 : bus.data0;

    // Occupancy next-state from the accepted push/pop pair
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, occupancy and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_err_udf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_rd_valid <= w_pop;
            if (bus.pop && w_empty) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    // Pointer distance must always agree with the registered occupancy
    assign w_ptr_occ = r_wr_ptr - r_rd_ptr;

    a_occ_consistent: assert property (@(posedge clk) disable iff (rst)
        w_ptr_occ == r_count);

    assign bus.gnt0      = w_gnt[0];
    assign bus.gnt1      = w_gnt[1];
    assign bus.mem_we    = w_push;
    assign bus.mem_waddr = r_wr_ptr[ADDR_W-1:0];
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_raddr = r_rd_ptr[ADDR_W-1:0];
    assign bus.rd_valid  = r_rd_valid;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.err_udf   = r_err_udf;

endmodule
`default_nettype wire
